// File: rtl/v_sram_mp.sv
// Multi-port SRAM: two write ports, two read ports, zero-fill after reset.
// Read latency 1 or 2; optional same-cycle write-to-read forwarding.
module v_sram_mp #(
  parameter int DATA_W     = 48,
  parameter int ADDR_W     = 9,
  parameter int DEPTH      = 512,
  parameter int RD_LAT     = 1,
  parameter int WR_FWD     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid1,
  output logic              rvalid2,
  output logic              wr_collide,
  output logic              init_busy
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              col_q, col_d;
  logic [1:0]        pipe_v_q, pipe_v_d;
  logic [DATA_W-1:0] pipe_q [2];
  logic [DATA_W-1:0] pipe_d [2];
  logic [1:0]        rv_q, rv_d;
  logic [DATA_W-1:0] rd_q [2];
  logic [DATA_W-1:0] rd_d [2];

  logic [DATA_W-1:0] mem [DEPTH];

  logic              act;
  logic              clr_we;
  logic              wv1, wv2;
  logic [1:0]        rd_req;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rval [2];
  logic [1:0]        out_v;
  logic [DATA_W-1:0] out_d [2];

  // Requests only count in READY with reset released.
  assign act    = (state_q == ST_READY) && reset_n;
  assign clr_we = (state_q == ST_CLEAR) && reset_n;
  assign wv1    = act && we1 && ({1'b0, waddr1} < DEPTH_C);
  assign wv2    = act && we2 && ({1'b0, waddr2} < DEPTH_C);
  assign rd_req = {act && re2, act && re1};
  assign ra[0]  = raddr1;
  assign ra[1]  = raddr2;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == ST_CLEAR) begin
      if (clr_q == LAST_C) begin
        state_d = ST_READY;
        clr_d   = '0;
      end else begin
        clr_d = clr_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rval[i] = '0;
      if ({1'b0, ra[i]} < DEPTH_C) begin
        rval[i] = mem[ra[i]];
        // Port 2 wins when both writers hit the read address.
        if (WR_FWD != 0) begin
          if (wv2 && (waddr2 == ra[i])) begin
            rval[i] = wdata2;
          end else if (wv1 && (waddr1 == ra[i])) begin
            rval[i] = wdata1;
          end
        end
      end
    end
  end

  always_comb begin
    col_d    = wv1 && wv2 && (waddr1 == waddr2);
    pipe_v_d = rd_req;
    pipe_d   = rval;
    if (RD_LAT == 2) begin
      out_v = pipe_v_q;
      out_d = pipe_q;
    end else begin
      out_v = rd_req;
      out_d = rval;
    end
    rv_d = out_v;
    for (int i = 0; i < 2; i++) begin
      rd_d[i] = out_v[i] ? out_d[i] : rd_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      clr_q    <= '0;
      col_q    <= 1'b0;
      pipe_v_q <= '0;
      rv_q     <= '0;
      rd_q[0]  <= '0;
      rd_q[1]  <= '0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      col_q    <= col_d;
      pipe_v_q <= pipe_v_d;
      rv_q     <= rv_d;
      rd_q[0]  <= rd_d[0];
      rd_q[1]  <= rd_d[1];
    end
  end

  always_ff @(posedge clock) begin
    pipe_q[0] <= pipe_d[0];
    pipe_q[1] <= pipe_d[1];
  end

  // Later assignment wins, so port 2 owns a collided address.
  always_ff @(posedge clock) begin
    if (clr_we) mem[clr_q] <= '0;
    if (wv1) mem[waddr1] <= wdata1;
    if (wv2) mem[waddr2] <= wdata2;
  end

  assign rdata1     = rd_q[0];
  assign rdata2     = rd_q[1];
  assign rvalid1    = rv_q[0];
  assign rvalid2    = rv_q[1];
  assign wr_collide = col_q;
  assign init_busy  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_v_sram_mp.sv
// Bench for v_sram_mp: default instance plus a DEPTH=300, RD_LAT=2,
// WR_FWD=0 instance, both checked against an array-based model.
module tb_v_sram_mp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        we1, we2, re1, re2;
  logic [8:0]  waddr1, waddr2, raddr1, raddr2;
  logic [47:0] wdata1, wdata2;

  logic [47:0] o_rd1 [2];
  logic [47:0] o_rd2 [2];
  logic        o_rv1 [2];
  logic        o_rv2 [2];
  logic        o_col [2];
  logic        o_busy [2];

  v_sram_mp u0 (
    .clock(clock), .reset_n(reset_n),
    .we1(we1), .we2(we2),
    .waddr1(waddr1), .waddr2(waddr2),
    .wdata1(wdata1), .wdata2(wdata2),
    .re1(re1), .re2(re2),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(o_rd1[0]), .rdata2(o_rd2[0]),
    .rvalid1(o_rv1[0]), .rvalid2(o_rv2[0]),
    .wr_collide(o_col[0]), .init_busy(o_busy[0])
  );

  v_sram_mp #(.DEPTH(300), .RD_LAT(2), .WR_FWD(0)) u1 (
    .clock(clock), .reset_n(reset_n),
    .we1(we1), .we2(we2),
    .waddr1(waddr1), .waddr2(waddr2),
    .wdata1(wdata1), .wdata2(wdata2),
    .re1(re1), .re2(re2),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(o_rd1[1]), .rdata2(o_rd2[1]),
    .rvalid1(o_rv1[1]), .rvalid2(o_rv2[1]),
    .wr_collide(o_col[1]), .init_busy(o_busy[1])
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;
  int cnt;

  function automatic int dep(int k);
    return (k == 0) ? 512 : 300;
  endfunction

  function automatic int lat(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic bit fwd(int k);
    return (k == 0);
  endfunction

  // Reference model: plain array per instance plus a busy countdown.
  logic [47:0] mm [2][512];
  int          busy [2];
  logic        e_rv [2][2];
  logic [47:0] e_rd [2][2];
  logic        pv [2][2];
  logic [47:0] pd [2][2];
  logic        e_col [2];
  logic        m_act;
  logic        m_nv [2];
  logic [47:0] m_nd [2];
  logic [8:0]  m_ra [2];
  logic        m_re [2];

  always @(posedge clock) begin
    m_ra[0] = raddr1;
    m_ra[1] = raddr2;
    m_re[0] = re1;
    m_re[1] = re2;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        busy[k]  = dep(k);
        e_col[k] = 1'b0;
        for (int a = 0; a < 512; a++) mm[k][a] = '0;
        for (int p = 0; p < 2; p++) begin
          e_rv[k][p] = 1'b0;
          e_rd[k][p] = '0;
          pv[k][p]   = 1'b0;
          pd[k][p]   = '0;
        end
      end else begin
        m_act = (busy[k] == 0);
        if (!m_act) busy[k]--;
        for (int p = 0; p < 2; p++) begin
          m_nv[p] = m_act && m_re[p];
          m_nd[p] = '0;
          if (m_ra[p] < dep(k)) begin
            m_nd[p] = mm[k][m_ra[p]];
            if (fwd(k)) begin
              if (we2 && waddr2 == m_ra[p]) m_nd[p] = wdata2;
              else if (we1 && waddr1 == m_ra[p]) m_nd[p] = wdata1;
            end
          end
        end
        if (m_act && we1 && waddr1 < dep(k)) mm[k][waddr1] = wdata1;
        if (m_act && we2 && waddr2 < dep(k)) mm[k][waddr2] = wdata2;
        e_col[k] = m_act && we1 && we2 &&
                   (waddr1 == waddr2) && (waddr1 < dep(k));
        for (int p = 0; p < 2; p++) begin
          if (lat(k) == 1) begin
            e_rv[k][p] = m_nv[p];
            if (m_nv[p]) e_rd[k][p] = m_nd[p];
          end else begin
            e_rv[k][p] = pv[k][p];
            if (pv[k][p]) e_rd[k][p] = pd[k][p];
            pv[k][p] = m_nv[p];
            pd[k][p] = m_nd[p];
          end
        end
      end
    end
  end

  task automatic chk(string tag, logic [47:0] obs, logic [47:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d_rdata1", k), o_rd1[k], e_rd[k][0]);
      chk($sformatf("u%0d_rdata2", k), o_rd2[k], e_rd[k][1]);
      chk($sformatf("u%0d_rvalid1", k), 48'(o_rv1[k]), 48'(e_rv[k][0]));
      chk($sformatf("u%0d_rvalid2", k), 48'(o_rv2[k]), 48'(e_rv[k][1]));
      chk($sformatf("u%0d_collide", k), 48'(o_col[k]), 48'(e_col[k]));
      chk($sformatf("u%0d_busy", k), 48'(o_busy[k]), 48'(busy[k] != 0));
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle();
    we1 = 0; we2 = 0; re1 = 0; re2 = 0;
    waddr1 = '0; waddr2 = '0; raddr1 = '0; raddr2 = '0;
    wdata1 = '0; wdata2 = '0;
  endtask

  function automatic logic [8:0] r_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 9'($urandom_range(0, 15));
    if (r < 9) return 9'($urandom_range(0, 511));
    return 9'($urandom_range(290, 511));
  endfunction

  task automatic rnd();
    we1 = 1'($urandom_range(0, 1));
    we2 = 1'($urandom_range(0, 1));
    re1 = ($urandom_range(0, 3) != 0);
    re2 = ($urandom_range(0, 3) != 0);
    waddr1 = r_addr(); waddr2 = r_addr();
    raddr1 = r_addr(); raddr2 = r_addr();
    wdata1 = {16'($urandom), $urandom};
    wdata2 = {16'($urandom), $urandom};
  endtask

  initial begin
    reset_n = 0;
    idle();
    repeat (3) step();

    reset_n = 1;
    cnt = 0;
    while (o_busy[0] && cnt < 2000) begin
      cnt++;
      rnd();
      step();
    end
    chk("busy_len", 48'(cnt), 48'd512);

    idle(); re1 = 1; raddr1 = 9'd511;
    step();
    chk("rd511_valid", 48'(o_rv1[0]), 48'd1);
    chk("rd511_data", o_rd1[0], 48'd0);

    idle(); we1 = 1; waddr1 = 9'd5; wdata1 = 48'hA5A5_0000_1234;
    step();
    idle(); re1 = 1; raddr1 = 9'd5;
    step();
    idle();
    chk("lat1_data", o_rd1[0], 48'hA5A5_0000_1234);
    chk("lat1_valid", 48'(o_rv1[0]), 48'd1);
    chk("lat2_early", 48'(o_rv1[1]), 48'd0);
    step();
    chk("lat2_data", o_rd1[1], 48'hA5A5_0000_1234);
    chk("lat2_valid", 48'(o_rv1[1]), 48'd1);
    chk("lat1_drop", 48'(o_rv1[0]), 48'd0);

    idle(); we1 = 1; we2 = 1; waddr1 = 9'd7; waddr2 = 9'd7;
    wdata1 = 48'h1; wdata2 = 48'h2;
    step();
    chk("collide_u0", 48'(o_col[0]), 48'd1);
    chk("collide_u1", 48'(o_col[1]), 48'd1);
    idle();
    step();
    chk("collide_end", 48'(o_col[0]), 48'd0);
    re1 = 1; raddr1 = 9'd7;
    step();
    idle();
    chk("collide_rd_u0", o_rd1[0], 48'h2);
    step();
    chk("collide_rd_u1", o_rd1[1], 48'h2);

    idle(); we1 = 1; waddr1 = 9'd3; wdata1 = 48'h0;
    step();
    idle(); we1 = 1; waddr1 = 9'd3; wdata1 = 48'hBEEF;
    re1 = 1; raddr1 = 9'd3;
    step();
    idle();
    chk("fwd_on", o_rd1[0], 48'hBEEF);
    step();
    chk("fwd_off", o_rd1[1], 48'h0);
    chk("fwd_off_valid", 48'(o_rv1[1]), 48'd1);

    idle(); we1 = 1; waddr1 = 9'd299; wdata1 = 48'h1234_5678_9ABC;
    step();
    idle(); we1 = 1; waddr1 = 9'd400; wdata1 = 48'hDEAD;
    step();
    idle(); re1 = 1; raddr1 = 9'd400; re2 = 1; raddr2 = 9'd299;
    step();
    idle();
    chk("oor_u0_in_range", o_rd1[0], 48'hDEAD);
    step();
    chk("oor_u1_data", o_rd1[1], 48'h0);
    chk("oor_u1_valid", 48'(o_rv1[1]), 48'd1);
    chk("oor_u1_299", o_rd2[1], 48'h1234_5678_9ABC);

    repeat (800) begin
      rnd();
      step();
    end

    reset_n = 0;
    idle();
    step();
    reset_n = 1;
    repeat (100) begin
      rnd();
      step();
    end
    reset_n = 0;
    step();
    reset_n = 1;
    cnt = 0;
    while (o_busy[0] && cnt < 2000) begin
      cnt++;
      rnd();
      step();
    end
    chk("busy_len_restart", 48'(cnt), 48'd512);

    repeat (200) begin
      rnd();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
